// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: MEM-stage port, DMA/debug port and RAM port.
// slave is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_done;
  logic [DW-1:0] dma_rdata;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_done, dma_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_done, dma_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous data RAM between the MEM stage and a DMA/debug port.
// Define DMEM_ARB_FAIR_EN to compile in the DMA starvation guard.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_WAIT, DMA_ACC, DMA_WAIT} state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t        state_reg, state_next;
  logic [1:0]    lat_reg, lat_next;
  logic          dma_done_reg;
  logic [DW-1:0] dma_rdata_reg;

  logic          cpu_req;
  logic          cpu_done;
  logic          dma_fin;
  logic          dma_first;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  assign cpu_req = bus.mem_read | bus.mem_write;

`ifdef DMEM_ARB_FAIR_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_reg;
  logic       in_dma;

  assign in_dma    = (state_reg == DMA_ACC) || (state_reg == DMA_WAIT);
  assign dma_first = bus.dma_req && (starve_reg >= STARVE_LIM);

  // Counts cycles the DMA port has been kept waiting; saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_reg <= '0;
    end else if (state_reg == IDLE && state_next == DMA_ACC) begin
      starve_reg <= '0;
    end else if (bus.dma_req && !in_dma && starve_reg != 4'hF) begin
      starve_reg <= starve_reg + 4'd1;
    end
  end
`else
  logic [3:0] unused_starve_max;
  assign unused_starve_max = 4'(STARVE_MAX);
  assign dma_first         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      lat_reg       <= '0;
      dma_done_reg  <= 1'b0;
      dma_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lat_reg      <= lat_next;
      dma_done_reg <= dma_fin;
      if (dma_fin && state_reg == DMA_WAIT) begin
        dma_rdata_reg <= bus.ram_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    cpu_done   = 1'b0;
    dma_fin    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dma_first) begin
          state_next = DMA_ACC;
        end else if (cpu_req) begin
          state_next = CPU_ACC;
        end else if (bus.dma_req) begin
          state_next = DMA_ACC;
        end
      end
      CPU_ACC: begin
        ram_en    = 1'b1;
        ram_we    = bus.mem_write;
        ram_addr  = bus.mem_addr;
        ram_wdata = bus.mem_wdata;
        if (bus.mem_write) begin
          cpu_done   = 1'b1;
          state_next = IDLE;
        end else begin
          lat_next   = LAT;
          state_next = CPU_WAIT;
        end
      end
      CPU_WAIT: begin
        lat_next = lat_reg - 2'd1;
        if (lat_reg == 2'd1) begin
          cpu_done   = 1'b1;
          state_next = IDLE;
        end
      end
      DMA_ACC: begin
        ram_en    = 1'b1;
        ram_we    = bus.dma_we;
        ram_addr  = bus.dma_addr;
        ram_wdata = bus.dma_wdata;
        if (bus.dma_we) begin
          dma_fin    = 1'b1;
          state_next = IDLE;
        end else begin
          lat_next   = LAT;
          state_next = DMA_WAIT;
        end
      end
      DMA_WAIT: begin
        lat_next = lat_reg - 2'd1;
        if (lat_reg == 2'd1) begin
          dma_fin    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A DMA access keeps the pipeline frozen because cpu_done stays low outside CPU states.
  assign bus.stall     = cpu_req & ~cpu_done;
  assign bus.mem_rdata = bus.ram_rdata;
  assign bus.dma_done  = dma_done_reg;
  assign bus.dma_rdata = dma_rdata_reg;
  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against an array model of memory and latency rules.
module tb_dmem_arbiter;
  localparam int AW         = 8;
  localparam int DW         = 16;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with RD_LAT-cycle read latency and a backdoor write port
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  logic          bk_we;
  logic [AW-1:0] bk_addr;
  logic [DW-1:0] bk_data;

  always @(posedge clk) begin
    if (bk_we) ram_mem[bk_addr] <= bk_data;
    else if (bus.ram_en && bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    rd_pipe[0] <= ram_mem[bus.ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.ram_rdata = rd_pipe[RD_LAT-1];

  logic [DW-1:0] ref_mem [0:15];

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    next_cycle();
    bk_we = 1'b0;
  endtask

  // Runs one MEM-stage access from an idle arbiter; lat = cycle index where stall drops.
  task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat, output logic [DW-1:0] rd);
    bus.mem_read = !we; bus.mem_write = we; bus.mem_addr = a; bus.mem_wdata = d;
    lat = -1; rd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.stall) begin
        lat = c; rd = bus.mem_rdata;
        break;
      end
      next_cycle();
    end
    next_cycle();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  // Runs one DMA access; the requester drops dma_req in the cycle dma_done is seen.
  task automatic dma_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat, output logic [DW-1:0] rd, output logic extra);
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    lat = -1; rd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.dma_done) begin
        lat = c; rd = bus.dma_rdata;
        break;
      end
      next_cycle();
    end
    bus.dma_req = 1'b0;
    next_cycle();
    @(negedge clk);
    extra = bus.dma_done;
    next_cycle();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++; if (bus.ram_en !== 1'b0) $display("FAIL reset_ram_en: got %b want 0", bus.ram_en); else passes++;
    checks++; if (bus.ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); else passes++;
    checks++; if (bus.dma_done !== 1'b0) $display("FAIL reset_dma_done: got %b want 0", bus.dma_done); else passes++;
    checks++; if (bus.dma_rdata !== 16'h0) $display("FAIL reset_dma_rdata: got %h want 0000", bus.dma_rdata); else passes++;
    checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall_lo: got %b want 0", bus.stall); else passes++;
    bus.mem_read = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b1) $display("FAIL reset_stall_follow: got %b want 1", bus.stall); else passes++;
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_store;
    bus.mem_write = 1'b1; bus.mem_addr = 8'h12; bus.mem_wdata = 16'hBEEF;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) $display("FAIL store_c0_stall: got %b want 1", bus.stall); else passes++;
    checks++; if (bus.ram_en !== 1'b0) $display("FAIL store_c0_ram_en: got %b want 0", bus.ram_en); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if ({bus.ram_en, bus.ram_we} !== 2'b11) $display("FAIL store_c1_en_we: got %b want 11", {bus.ram_en, bus.ram_we}); else passes++;
    checks++; if (bus.ram_addr !== 8'h12) $display("FAIL store_c1_addr: got %h want 12", bus.ram_addr); else passes++;
    checks++; if (bus.ram_wdata !== 16'hBEEF) $display("FAIL store_c1_wdata: got %h want beef", bus.ram_wdata); else passes++;
    checks++; if (bus.stall !== 1'b0) $display("FAIL store_c1_stall: got %b want 0", bus.stall); else passes++;
    next_cycle();
    bus.mem_write = 1'b0;
    @(negedge clk);
    checks++; if (ram_mem[8'h12] !== 16'hBEEF) $display("FAIL store_ram_content: got %h want beef", ram_mem[8'h12]); else passes++;
    next_cycle();
  endtask

  task automatic test_load;
    backdoor(8'h05, 16'h1234);
    bus.mem_read = 1'b1; bus.mem_addr = 8'h05;
    for (int c = 0; c <= 1 + RD_LAT; c++) begin
      @(negedge clk);
      checks++; if (bus.stall !== (c < 1 + RD_LAT)) $display("FAIL load_stall_c%0d: got %b want %b", c, bus.stall, (c < 1 + RD_LAT)); else passes++;
      checks++; if (bus.ram_en !== (c == 1)) $display("FAIL load_ram_en_c%0d: got %b want %b", c, bus.ram_en, (c == 1)); else passes++;
      if (c == 1) begin
        checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h05) $display("FAIL load_strobe: got we=%b addr=%h want we=0 addr=05", bus.ram_we, bus.ram_addr); else passes++;
      end
      if (c == 1 + RD_LAT) begin
        checks++; if (bus.mem_rdata !== 16'h1234) $display("FAIL load_rdata: got %h want 1234", bus.mem_rdata); else passes++;
      end
      next_cycle();
    end
    bus.mem_read = 1'b0;
    next_cycle();
  endtask

  task automatic test_dma_read;
    int lat; logic [DW-1:0] rd; logic extra;
    backdoor(8'h40, 16'hA5A5);
    dma_access(1'b0, 8'h40, '0, lat, rd, extra);
    checks++; if (lat !== RD_LAT + 2) $display("FAIL dma_read_latency: got %0d want %0d", lat, RD_LAT + 2); else passes++;
    checks++; if (rd !== 16'hA5A5) $display("FAIL dma_read_data: got %h want a5a5", rd); else passes++;
    checks++; if (extra !== 1'b0) $display("FAIL dma_done_single_pulse: got %b want 0", extra); else passes++;
  endtask

  task automatic test_back_to_back;
    bus.mem_write = 1'b1; bus.mem_addr = 8'h20; bus.mem_wdata = 16'h0101;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.ram_en !== 1'b1) $display("FAIL b2b_first_strobe: got %b want 1", bus.ram_en); else passes++;
    next_cycle();
    bus.mem_addr = 8'h21; bus.mem_wdata = 16'h0202;
    @(negedge clk);
    checks++; if (bus.ram_en !== 1'b0 || bus.stall !== 1'b1) $display("FAIL b2b_idle_gap: got en=%b stall=%b want en=0 stall=1", bus.ram_en, bus.stall); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 8'h21) $display("FAIL b2b_second_strobe: got en=%b addr=%h want en=1 addr=21", bus.ram_en, bus.ram_addr); else passes++;
    next_cycle();
    bus.mem_write = 1'b0;
    next_cycle();
  endtask

  task automatic test_fairness;
    int first; logic stall_at;
    first = -1; stall_at = 1'b0;
    rst = 1'b1; #2; rst = 1'b0;
    next_cycle();
    bus.mem_write = 1'b1; bus.mem_addr = 8'h10; bus.mem_wdata = 16'h1111;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h40;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.ram_en && bus.ram_addr == 8'h40 && first < 0) begin
        first = c; stall_at = bus.stall;
      end
      if (bus.dma_done) bus.dma_req = 1'b0;
      next_cycle();
    end
    bus.mem_write = 1'b0; bus.dma_req = 1'b0;
    repeat (6) next_cycle();
`ifdef DMEM_ARB_FAIR_EN
    checks++; if (first !== 5) $display("FAIL fair_dma_grant_cycle: got %0d want 5", first); else passes++;
    checks++; if (stall_at !== 1'b1) $display("FAIL fair_stall_during_dma: got %b want 1", stall_at); else passes++;
`else
    checks++; if (first !== -1) $display("FAIL strict_dma_never_granted: got strobe at cycle %0d want none", first); else passes++;
`endif
  endtask

  task automatic test_reset_mid;
    int lat; int pulses; logic [DW-1:0] rd;
    bus.mem_read = 1'b1; bus.mem_addr = 8'h05;
    next_cycle();
    #2;
    checks++; if (bus.ram_en !== 1'b1) $display("FAIL rstmid_pre_strobe: got %b want 1", bus.ram_en); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) $display("FAIL rstmid_ram_off: got en=%b we=%b want 0 0", bus.ram_en, bus.ram_we); else passes++;
    checks++; if (bus.stall !== 1'b1) $display("FAIL rstmid_stall_follow: got %b want 1", bus.stall); else passes++;
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    // DMA read abandoned in its wait phase
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h40;
    next_cycle();
    next_cycle();
    #2;
    rst = 1'b1;
    bus.dma_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      if (bus.dma_done) pulses++;
    end
    next_cycle();
    checks++; if (pulses !== 0) $display("FAIL rstmid_no_dma_done: got %0d pulses want 0", pulses); else passes++;
    checks++; if (bus.dma_rdata !== 16'h0) $display("FAIL rstmid_dma_rdata: got %h want 0000", bus.dma_rdata); else passes++;
    cpu_access(1'b0, 8'h05, '0, lat, rd);
    checks++; if (lat !== 1 + RD_LAT) $display("FAIL rstmid_reload_latency: got %0d want %0d", lat, 1 + RD_LAT); else passes++;
    checks++; if (rd !== 16'h1234) $display("FAIL rstmid_reload_data: got %h want 1234", rd); else passes++;
  endtask

  task automatic test_random;
    int lat; int kind; int idx; logic [DW-1:0] rd; logic [DW-1:0] d; logic extra;
    logic [AW-1:0] a;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = DW'($urandom);
      backdoor(AW'(8'h60 + i), ref_mem[i]);
    end
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      idx  = $urandom_range(0, 15);
      a    = AW'(8'h60 + idx);
      d    = DW'($urandom);
      case (kind)
        0: begin
          cpu_access(1'b1, a, d, lat, rd);
          ref_mem[idx] = d;
          $display("txn %0d: cpu store addr=%h data=%h lat=%0d", t, a, d, lat);
          checks++; if (lat !== 1) $display("FAIL rnd_cpu_store_lat t%0d: got %0d want 1", t, lat); else passes++;
        end
        1: begin
          cpu_access(1'b0, a, '0, lat, rd);
          $display("txn %0d: cpu load addr=%h data=%h lat=%0d", t, a, rd, lat);
          checks++; if (lat !== 1 + RD_LAT) $display("FAIL rnd_cpu_load_lat t%0d: got %0d want %0d", t, lat, 1 + RD_LAT); else passes++;
          checks++; if (rd !== ref_mem[idx]) $display("FAIL rnd_cpu_load_data t%0d: got %h want %h", t, rd, ref_mem[idx]); else passes++;
        end
        2: begin
          dma_access(1'b1, a, d, lat, rd, extra);
          ref_mem[idx] = d;
          $display("txn %0d: dma write addr=%h data=%h lat=%0d", t, a, d, lat);
          checks++; if (lat !== 2 || extra !== 1'b0) $display("FAIL rnd_dma_write t%0d: got lat=%0d extra=%b want lat=2 extra=0", t, lat, extra); else passes++;
        end
        default: begin
          dma_access(1'b0, a, '0, lat, rd, extra);
          $display("txn %0d: dma read addr=%h data=%h lat=%0d", t, a, rd, lat);
          checks++; if (lat !== RD_LAT + 2) $display("FAIL rnd_dma_read_lat t%0d: got %0d want %0d", t, lat, RD_LAT + 2); else passes++;
          checks++; if (rd !== ref_mem[idx]) $display("FAIL rnd_dma_read_data t%0d: got %h want %h", t, rd, ref_mem[idx]); else passes++;
        end
      endcase
      repeat ($urandom_range(0, 2)) next_cycle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; passes = 0;
    bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    rst = 1'b1;
    test_reset();
    test_store();
    test_load();
    test_dma_read();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
